// File: rtl/hello_scroll_ctrl.sv
// hello_scroll_ctrl: scrolls "HELLO   " across NUM_DIGITS 7-seg digits.
// Ports: i_clk, i_rst (sync, active-high), i_run, i_step, i_dir,
//        o_codes (3 bits/digit, digit0 = LSBs), o_pos, o_tick.
module hello_scroll_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int TICK_DIV   = 50000000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_run,
  input  logic                    i_step,
  input  logic                    i_dir,
  output logic [3*NUM_DIGITS-1:0] o_codes,
  output logic [2:0]              o_pos,
  output logic                    o_tick
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_TERM = DW'(TICK_DIV - 1);
  localparam logic [2:0] C_BLANK = 3'd4;

  typedef enum logic [1:0] {
    S_BLANK,
    S_HOLD,
    S_RUN
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_pos;
  logic [2:0]    w_pos_nxt;
  logic [DW-1:0] r_div;
  logic [DW-1:0] w_div_nxt;
  logic          r_tick;
  logic          w_adv;
  logic [3*NUM_DIGITS-1:0] r_codes;
  logic [3*NUM_DIGITS-1:0] w_codes_nxt;

  function automatic logic [2:0] f_msg(
    input logic [2:0] idx
  );
    logic [2:0] c;
    case (idx)
      3'd0:    c = 3'd0;
      3'd1:    c = 3'd1;
      3'd2:    c = 3'd2;
      3'd3:    c = 3'd2;
      3'd4:    c = 3'd3;
      default: c = C_BLANK;
    endcase
    return c;
  endfunction

  // Leftmost digit shows msg[pos]; each digit to the right
  // shows the following message symbol (mod 8).
  function automatic logic [3*NUM_DIGITS-1:0] f_codes(
    input logic [2:0] pos
  );
    logic [3*NUM_DIGITS-1:0] v;
    logic [2:0]              idx;
    v = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      idx = pos + 3'(NUM_DIGITS - 1 - d);
      v[3*d +: 3] = f_msg(idx);
    end
    return v;
  endfunction

  function automatic logic [3*NUM_DIGITS-1:0] f_blank();
    logic [3*NUM_DIGITS-1:0] v;
    v = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      v[3*d +: 3] = C_BLANK;
    end
    return v;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_BLANK;
      r_pos   <= 3'd0;
      r_div   <= '0;
      r_tick  <= 1'b0;
      r_codes <= f_blank();
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_div   <= w_div_nxt;
      r_tick  <= w_adv;
      r_codes <= w_codes_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_adv       = 1'b0;
    unique case (r_state)
      S_BLANK: begin
        if (i_run) begin
          w_state_nxt = S_RUN;
          w_div_nxt   = '0;
        end else if (i_step) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_run) begin
          w_state_nxt = S_RUN;
          w_div_nxt   = '0;
        end else if (i_step) begin
          w_adv = 1'b1;
        end
      end
      S_RUN: begin
        // Leaving RUN never advances, even at terminal count.
        if (!i_run) begin
          w_state_nxt = S_HOLD;
          w_div_nxt   = '0;
        end else if (r_div == DIV_TERM) begin
          w_adv     = 1'b1;
          w_div_nxt = '0;
        end else begin
          w_div_nxt = r_div + DW'(1);
        end
      end
      default: begin
        w_state_nxt = S_BLANK;
        w_div_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_pos_nxt = r_pos;
    if (w_adv) begin
      w_pos_nxt = i_dir ? r_pos - 3'd1 : r_pos + 3'd1;
    end
  end

  // Codes are computed from next-state values so they land
  // on the same edge as Pos and Tick.
  always_comb begin
    if (w_state_nxt == S_BLANK) begin
      w_codes_nxt = f_blank();
    end else begin
      w_codes_nxt = f_codes(w_pos_nxt);
    end
  end

  assign o_codes = r_codes;
  assign o_pos   = r_pos;
  assign o_tick  = r_tick;

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// tb_hello_scroll_ctrl: directed + random bench for hello_scroll_ctrl.
// Reference model tracks visibility, run mode, offset and edge count.
module tb_hello_scroll_ctrl;

  localparam int ND = 4;
  localparam int TD = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            run;
  logic            step;
  logic            dir;
  logic [3*ND-1:0] codes;
  logic [2:0]      pos;
  logic            tick;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_shown;
  bit m_running;
  int m_pos;
  int m_cnt;
  bit m_tick;
  int msg [8] = '{0, 1, 2, 2, 3, 4, 4, 4};

  hello_scroll_ctrl #(
    .NUM_DIGITS(ND),
    .TICK_DIV(TD)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_run  (run),
    .i_step (step),
    .i_dir  (dir),
    .o_codes(codes),
    .o_pos  (pos),
    .o_tick (tick)
  );

  always #5 clk = ~clk;

  function automatic logic [3*ND-1:0] exp_codes();
    logic [3*ND-1:0] v;
    v = '0;
    for (int d = 0; d < ND; d++) begin
      if (!m_shown) v[3*d +: 3] = 3'd4;
      else v[3*d +: 3] = 3'(msg[(m_pos + ND - 1 - d) % 8]);
    end
    return v;
  endfunction

  task automatic model_edge();
    m_tick = 1'b0;
    if (rst) begin
      m_shown = 0; m_running = 0; m_pos = 0; m_cnt = 0;
    end else if (!m_shown) begin
      if (run) begin
        m_shown = 1; m_running = 1; m_cnt = 0;
      end else if (step) begin
        m_shown = 1;
      end
    end else if (!m_running) begin
      if (run) begin
        m_running = 1; m_cnt = 0;
      end else if (step) begin
        m_pos = (m_pos + (dir ? 7 : 1)) % 8;
        m_tick = 1'b1;
      end
    end else if (!run) begin
      m_running = 0;
    end else begin
      m_cnt++;
      if (m_cnt == TD) begin
        m_cnt = 0;
        m_pos = (m_pos + (dir ? 7 : 1)) % 8;
        m_tick = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Apply inputs, clock one edge, update model, compare #1 later.
  task automatic cyc(input bit r, input bit rn, input bit st,
                     input bit dr);
    rst = r; run = rn; step = st; dir = dr;
    @(posedge clk);
    model_edge();
    #1;
    chk("codes", int'(codes), int'(exp_codes()));
    chk("pos", int'(pos), m_pos);
    chk("tick", int'(tick), int'(m_tick));
  endtask

  initial begin
    int guard;
    rst = 1; run = 0; step = 0; dir = 0;
    m_shown = 0; m_running = 0; m_pos = 0; m_cnt = 0; m_tick = 0;
    @(negedge clk);

    // Reset then idle
    cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    chk("idle_blank", int'(codes), 'h924);

    // Manual stepping from BLANK
    cyc(0, 0, 1, 0);
    chk("hello", int'(codes), 'h052);
    chk("no_tick_enter", int'(tick), 0);
    cyc(0, 0, 1, 0);
    chk("step1", int'(codes), 'h293);
    chk("step1_tick", int'(tick), 1);
    cyc(0, 0, 0, 0);
    chk("tick_once", int'(tick), 0);

    // Wrap down then 8 steps back round
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    chk("wrap_codes", int'(codes), 'h80A);
    chk("wrap_pos", int'(pos), 7);
    repeat (8) cyc(0, 0, 1, 0);
    chk("lap_codes", int'(codes), 'h80A);

    // Automatic run from HOLD pos 0, with ignored steps
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 1, (i % 3) == 1, 0);
      if (i == 4) chk("run_first", int'(codes), 'h293);
    end
    chk("run_pos3", int'(pos), 3);

    // Drop Run with divider at 2, then re-raise
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(0, 1, 0, 0);
    chk("rerun_pos", int'(pos), 4);

    // Reset mid-run at pos 5
    guard = 0;
    while (m_pos != 5 && guard < 40) begin
      cyc(0, 1, 0, 0);
      guard++;
    end
    chk("reach_pos5", int'(pos), 5);
    cyc(1, 1, 0, 0);
    chk("rst_run", int'(codes), 'h924);
    cyc(0, 1, 0, 0);
    chk("rerun_hello", int'(codes), 'h052);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 59) == 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 4) == 0));
    end
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 1) == 0),
          1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
